// File: rtl/rv32_decode_execute_if.sv
// Decode/execute bus of the single-cycle RV32I core: the fetched instruction and operands
// going in, and the register, memory, ALU, jump and LED controls coming out.
interface rv32_decode_execute_if;
  logic [31:0] instruction;
  logic [31:0] program_counter;
  logic [31:0] reg_read_data1;
  logic [31:0] reg_read_data2;
  logic [4:0]  reg_read_address1;
  logic [4:0]  reg_read_address2;
  logic [4:0]  reg_write_address;
  logic [31:0] immediate;
  logic [4:0]  alu_op;
  logic [2:0]  load_operation;
  logic [2:0]  store_operation;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic        reg_read_enable;
  logic        reg_write_enable;
  logic        jump;
  logic        is_jal;
  logic        is_jalr;
  logic        illegal;
  logic [31:0] alu_result;
  logic        zero;
  logic [31:0] jump_address;
  logic [15:0] leds;

  modport master (
    output instruction, program_counter, reg_read_data1, reg_read_data2,
    input  reg_read_address1, reg_read_address2, reg_write_address, immediate, alu_op,
           load_operation, store_operation, mem_read_enable, mem_write_enable,
           reg_read_enable, reg_write_enable, jump, is_jal, is_jalr, illegal,
           alu_result, zero, jump_address, leds
  );

  modport slave (
    input  instruction, program_counter, reg_read_data1, reg_read_data2,
    output reg_read_address1, reg_read_address2, reg_write_address, immediate, alu_op,
           load_operation, store_operation, mem_read_enable, mem_write_enable,
           reg_read_enable, reg_write_enable, jump, is_jal, is_jalr, illegal,
           alu_result, zero, jump_address, leds
  );
endinterface

// File: rtl/rv32_decode_execute.sv
// RV32I decode/execute slice: push-button debouncer, combinational control decoder,
// and a 32-bit ALU with branch/jump target generation.
module rv32_decode_execute #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        btn_raw,
  output logic                        btn_clean,
  rv32_decode_execute_if.slave        bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [4:0] {
    ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3, ALU_SLTU = 5'd4,
    ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7, ALU_OR = 5'd8, ALU_AND = 5'd9,
    ALU_PASS_B = 5'd10
  } alu_op_e;

  typedef enum logic [1:0] {B_RS2, B_IMM, B_FOUR} b_sel_e;

  // ---------------- Debouncer ----------------
  logic             sync1_q, sync1_d, sync2_q, sync2_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             btn_clean_q, btn_clean_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sync1_d     = btn_raw;
    sync2_d     = sync1_q;
    count_d     = count_q;
    btn_clean_d = btn_clean_q;
    if (sync2_q == btn_clean_q) begin
      count_d = '0;
    end else if (count_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      btn_clean_d = sync2_q;
      count_d     = '0;
    end else begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      count_q     <= '0;
      btn_clean_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      count_q     <= count_d;
      btn_clean_q <= btn_clean_d;
    end
  end

  assign btn_clean = btn_clean_q;

  // ---------------- Decoder ----------------
  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm;
  alu_op_e     alu_op, alu_rr;
  b_sel_e      b_sel;
  logic        a_is_pc, is_branch, take_branch, wr_en;

  assign ins    = bus.instruction;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign imm_i  = {{20{ins[31]}}, ins[31:20]};
  assign imm_s  = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b  = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u  = {ins[31:12], 12'b0};
  assign imm_j  = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // funct7[5] picks SUB only for register ADD; SRA/SRAI for shift-right in both formats.
  always_comb begin
    alu_rr = ALU_ADD;
    unique case (funct3)
      3'b000: alu_rr = (ins[30] && opcode == OP_R) ? ALU_SUB : ALU_ADD;
      3'b001: alu_rr = ALU_SLL;
      3'b010: alu_rr = ALU_SLT;
      3'b011: alu_rr = ALU_SLTU;
      3'b100: alu_rr = ALU_XOR;
      3'b101: alu_rr = ins[30] ? ALU_SRA : ALU_SRL;
      3'b110: alu_rr = ALU_OR;
      3'b111: alu_rr = ALU_AND;
      default: alu_rr = ALU_ADD;
    endcase
  end

  always_comb begin
    unique case (funct3)
      3'b000:  take_branch = bus.reg_read_data1 == bus.reg_read_data2;
      3'b001:  take_branch = bus.reg_read_data1 != bus.reg_read_data2;
      3'b100:  take_branch = $signed(bus.reg_read_data1) <  $signed(bus.reg_read_data2);
      3'b101:  take_branch = $signed(bus.reg_read_data1) >= $signed(bus.reg_read_data2);
      3'b110:  take_branch = bus.reg_read_data1 <  bus.reg_read_data2;
      3'b111:  take_branch = bus.reg_read_data1 >= bus.reg_read_data2;
      default: take_branch = 1'b0;
    endcase
  end

  always_comb begin
    imm                  = '0;
    alu_op               = ALU_ADD;
    b_sel                = B_RS2;
    a_is_pc              = 1'b0;
    is_branch            = 1'b0;
    wr_en                = 1'b0;
    bus.load_operation   = 3'b000;
    bus.store_operation  = 3'b000;
    bus.mem_read_enable  = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.reg_read_enable  = 1'b0;
    bus.jump             = 1'b0;
    bus.is_jal           = 1'b0;
    bus.is_jalr          = 1'b0;
    bus.illegal          = 1'b0;
    unique case (opcode)
      OP_R: begin
        alu_op = alu_rr; wr_en = 1'b1; bus.reg_read_enable = 1'b1;
      end
      OP_I: begin
        imm = imm_i; alu_op = alu_rr; b_sel = B_IMM; wr_en = 1'b1; bus.reg_read_enable = 1'b1;
      end
      OP_LOAD: begin
        imm = imm_i; b_sel = B_IMM; wr_en = 1'b1; bus.reg_read_enable = 1'b1;
        bus.mem_read_enable = 1'b1; bus.load_operation = funct3;
      end
      OP_STORE: begin
        imm = imm_s; b_sel = B_IMM; bus.reg_read_enable = 1'b1;
        bus.mem_write_enable = 1'b1; bus.store_operation = funct3;
      end
      // Branches compare rs1 with rs2 through the subtractor; the decision itself is take_branch.
      OP_BRANCH: begin
        imm = imm_b; alu_op = ALU_SUB; is_branch = 1'b1; bus.reg_read_enable = 1'b1;
        bus.jump = take_branch;
      end
      OP_JAL: begin
        imm = imm_j; a_is_pc = 1'b1; b_sel = B_FOUR; wr_en = 1'b1;
        bus.jump = 1'b1; bus.is_jal = 1'b1;
      end
      OP_JALR: begin
        imm = imm_i; a_is_pc = 1'b1; b_sel = B_FOUR; wr_en = 1'b1; bus.reg_read_enable = 1'b1;
        bus.jump = 1'b1; bus.is_jalr = 1'b1;
      end
      OP_LUI: begin
        imm = imm_u; alu_op = ALU_PASS_B; b_sel = B_IMM; wr_en = 1'b1;
      end
      OP_AUIPC: begin
        imm = imm_u; a_is_pc = 1'b1; b_sel = B_IMM; wr_en = 1'b1;
      end
      default: bus.illegal = 1'b1;
    endcase
  end

  // ---------------- ALU and targets ----------------
  logic [31:0] op_a, op_b, result;
  logic [4:0]  shamt;

  assign op_a  = a_is_pc ? bus.program_counter : bus.reg_read_data1;
  assign op_b  = (b_sel == B_IMM) ? imm : (b_sel == B_FOUR) ? 32'd4 : bus.reg_read_data2;
  assign shamt = op_b[4:0];

  always_comb begin
    unique case (alu_op)
      ALU_ADD:    result = op_a + op_b;
      ALU_SUB:    result = op_a - op_b;
      ALU_SLL:    result = op_a << shamt;
      ALU_SLT:    result = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   result = {31'b0, op_a < op_b};
      ALU_XOR:    result = op_a ^ op_b;
      ALU_SRL:    result = op_a >> shamt;
      ALU_SRA:    result = $unsigned($signed(op_a) >>> shamt);
      ALU_OR:     result = op_a | op_b;
      ALU_AND:    result = op_a & op_b;
      ALU_PASS_B: result = op_b;
      default:    result = '0;
    endcase
  end

  always_comb begin
    if (is_branch || bus.is_jal)  bus.jump_address = bus.program_counter + imm;
    else if (bus.is_jalr)         bus.jump_address = (bus.reg_read_data1 + imm) & ~32'd1;
    else                          bus.jump_address = '0;
  end

  assign bus.reg_read_address1 = ins[19:15];
  assign bus.reg_read_address2 = ins[24:20];
  assign bus.reg_write_address = ins[11:7];
  assign bus.immediate         = imm;
  assign bus.alu_op            = alu_op;
  assign bus.reg_write_enable  = wr_en && (ins[11:7] != 5'd0);
  assign bus.alu_result        = result;
  assign bus.zero              = (result == 32'd0);
  assign bus.leds = {opcode == OP_STORE, opcode == OP_LOAD, opcode == OP_I, opcode == OP_R,
                     ins[14], ins[13], ins[12], ins[30],
                     bus.reg_write_enable, bus.mem_write_enable, bus.mem_read_enable, alu_op};

endmodule

// File: tb/tb_rv32_decode_execute.sv
// Bench for rv32_decode_execute: directed decode/ALU vectors, debounce timing and reset,
// and randomized instructions checked against an instruction-level reference model.
module tb_rv32_decode_execute;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_raw = 1'b0;
  logic btn_clean;
  int   errors = 0;
  int   checks = 0;

  rv32_decode_execute_if bus_if();

  rv32_decode_execute #(.DEBOUNCE_CYCLES(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .btn_raw   (btn_raw),
    .btn_clean (btn_clean),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rs1_a, rs2_a, rd_a;
    logic [31:0] imm;
    logic [4:0]  alu_op;
    logic [2:0]  ld_op, st_op;
    logic        mre, mwe, rre, rwe, jump, is_jal, is_jalr, illegal;
    logic [31:0] result;
    logic        zero;
    logic [31:0] jaddr;
    logic [15:0] leds;
  } dec_t;

  function automatic dec_t observe();
    dec_t o;
    o = '{bus_if.reg_read_address1, bus_if.reg_read_address2, bus_if.reg_write_address,
          bus_if.immediate, bus_if.alu_op, bus_if.load_operation, bus_if.store_operation,
          bus_if.mem_read_enable, bus_if.mem_write_enable, bus_if.reg_read_enable,
          bus_if.reg_write_enable, bus_if.jump, bus_if.is_jal, bus_if.is_jalr, bus_if.illegal,
          bus_if.alu_result, bus_if.zero, bus_if.jump_address, bus_if.leds};
    return o;
  endfunction

  // Register/immediate arithmetic by funct3 as the ISA defines it.
  task automatic ref_alu(input logic [2:0] f3, input logic alt, input logic [31:0] a,
                         input logic [31:0] b, output logic [4:0] op, output logic [31:0] res);
    int sh;
    sh = int'(b[4:0]);
    case (f3)
      3'd0: begin op = alt ? 5'd1 : 5'd0; res = alt ? a - b : a + b; end
      3'd1: begin op = 5'd2; res = a << sh; end
      3'd2: begin op = 5'd3; res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
      3'd3: begin op = 5'd4; res = (a < b) ? 32'd1 : 32'd0; end
      3'd4: begin op = 5'd5; res = a ^ b; end
      3'd5: begin op = alt ? 5'd7 : 5'd6; res = alt ? 32'($signed(a) >>> sh) : a >> sh; end
      3'd6: begin op = 5'd8; res = a | b; end
      default: begin op = 5'd9; res = a & b; end
    endcase
  endtask

  task automatic model(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, output dec_t e);
    logic [2:0] f3;
    logic       wr;
    f3 = ins[14:12];
    wr = 1'b0;
    e  = '0;
    e.rs1_a = ins[19:15]; e.rs2_a = ins[24:20]; e.rd_a = ins[11:7];
    case (ins[6:0])
      7'h33: begin
        e.rre = 1; wr = 1;
        ref_alu(f3, ins[30] && (f3 == 3'd0 || f3 == 3'd5), a, b, e.alu_op, e.result);
      end
      7'h13: begin
        e.rre = 1; wr = 1; e.imm = {{20{ins[31]}}, ins[31:20]};
        ref_alu(f3, ins[30] && f3 == 3'd5, a, e.imm, e.alu_op, e.result);
      end
      7'h03: begin
        e.rre = 1; wr = 1; e.mre = 1; e.ld_op = f3;
        e.imm = {{20{ins[31]}}, ins[31:20]}; e.result = a + e.imm;
      end
      7'h23: begin
        e.rre = 1; e.mwe = 1; e.st_op = f3;
        e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; e.result = a + e.imm;
      end
      7'h63: begin
        e.rre = 1; e.alu_op = 5'd1; e.result = a - b;
        e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e.jaddr = pc + e.imm;
        case (f3)
          3'd0: e.jump = (a == b);
          3'd1: e.jump = (a != b);
          3'd4: e.jump = ($signed(a) < $signed(b));
          3'd5: e.jump = ($signed(a) >= $signed(b));
          3'd6: e.jump = (a < b);
          3'd7: e.jump = (a >= b);
          default: e.jump = 0;
        endcase
      end
      7'h6F: begin
        wr = 1; e.jump = 1; e.is_jal = 1; e.result = pc + 32'd4;
        e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        e.jaddr = pc + e.imm;
      end
      7'h67: begin
        e.rre = 1; wr = 1; e.jump = 1; e.is_jalr = 1; e.result = pc + 32'd4;
        e.imm = {{20{ins[31]}}, ins[31:20]};
        e.jaddr = (a + e.imm) & 32'hFFFF_FFFE;
      end
      7'h37: begin wr = 1; e.alu_op = 5'd10; e.imm = {ins[31:12], 12'h000}; e.result = e.imm; end
      7'h17: begin wr = 1; e.imm = {ins[31:12], 12'h000}; e.result = pc + e.imm; end
      default: begin e.illegal = 1; e.result = a + b; end
    endcase
    e.rwe  = wr && (ins[11:7] != 5'd0);
    e.zero = (e.result == 32'd0);
    e.leds = {ins[6:0] == 7'h23, ins[6:0] == 7'h03, ins[6:0] == 7'h13, ins[6:0] == 7'h33,
              ins[14], ins[13], ins[12], ins[30], e.rwe, e.mwe, e.mre, e.alu_op};
  endtask

  task automatic apply(input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] a, input logic [31:0] b);
    bus_if.instruction     = ins;
    bus_if.program_counter = pc;
    bus_if.reg_read_data1  = a;
    bus_if.reg_read_data2  = b;
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if (btn_clean !== 1'b0) begin errors++; $display("FAIL reset_clean got=%b exp=0", btn_clean); end
    @(posedge clk); #2 reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 checks++;
    if (btn_clean !== 1'b0) begin errors++; $display("FAIL idle_clean got=%b exp=0", btn_clean); end
  endtask

  task automatic test_add_sub();
    apply(32'h002081B3, 32'h0, 32'd5, 32'd7);
    checks++;
    if ({bus_if.alu_result, bus_if.reg_write_address, bus_if.reg_write_enable, bus_if.leds[12], bus_if.zero}
        !== {32'd12, 5'd3, 1'b1, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add got=%h/%0d/%b/%b/%b exp=0000000c/3/1/1/0", bus_if.alu_result,
        bus_if.reg_write_address, bus_if.reg_write_enable, bus_if.leds[12], bus_if.zero);
    end
    apply(32'h402081B3, 32'h0, 32'd5, 32'd7);
    checks++;
    if ({bus_if.alu_result, bus_if.alu_op, bus_if.leds[8]} !== {32'hFFFF_FFFE, 5'd1, 1'b1}) begin
      errors++; $display("FAIL sub got=%h/%0d/%b exp=fffffffe/1/1", bus_if.alu_result, bus_if.alu_op, bus_if.leds[8]);
    end
    apply(32'h402081B3, 32'h0, 32'd7, 32'd7);
    checks++;
    if ({bus_if.alu_result, bus_if.zero} !== {32'd0, 1'b1}) begin
      errors++; $display("FAIL sub_zero got=%h/%b exp=00000000/1", bus_if.alu_result, bus_if.zero);
    end
  endtask

  task automatic test_addi_sw();
    apply(32'hFFF00093, 32'h0, 32'd0, 32'd0);
    checks++;
    if ({bus_if.immediate, bus_if.alu_result, bus_if.leds[13]} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1}) begin
      errors++; $display("FAIL addi got=%h/%h/%b exp=ffffffff/ffffffff/1", bus_if.immediate, bus_if.alu_result, bus_if.leds[13]);
    end
    apply(32'h0020A423, 32'h0, 32'h100, 32'h55);
    checks++;
    if ({bus_if.immediate, bus_if.alu_result, bus_if.mem_write_enable, bus_if.store_operation, bus_if.reg_write_enable}
        !== {32'd8, 32'h108, 1'b1, 3'b010, 1'b0}) begin
      errors++; $display("FAIL sw got=%h/%h/%b/%b/%b exp=00000008/00000108/1/010/0", bus_if.immediate,
        bus_if.alu_result, bus_if.mem_write_enable, bus_if.store_operation, bus_if.reg_write_enable);
    end
  endtask

  task automatic test_branch_jal();
    apply(32'h00208463, 32'h100, 32'd5, 32'd5);
    checks++;
    if ({bus_if.jump, bus_if.jump_address} !== {1'b1, 32'h108}) begin
      errors++; $display("FAIL beq_taken got=%b/%h exp=1/00000108", bus_if.jump, bus_if.jump_address);
    end
    apply(32'h00208463, 32'h100, 32'd5, 32'd6);
    checks++;
    if (bus_if.jump !== 1'b0) begin errors++; $display("FAIL beq_not_taken got=%b exp=0", bus_if.jump); end
    apply(32'h010000EF, 32'h200, 32'd0, 32'd0);
    checks++;
    if ({bus_if.jump, bus_if.is_jal, bus_if.jump_address, bus_if.alu_result} !== {1'b1, 1'b1, 32'h210, 32'h204}) begin
      errors++; $display("FAIL jal got=%b/%b/%h/%h exp=1/1/00000210/00000204", bus_if.jump, bus_if.is_jal,
        bus_if.jump_address, bus_if.alu_result);
    end
  endtask

  task automatic test_illegal();
    apply(32'h0000007F, 32'h40, 32'd1, 32'd2);
    checks++;
    if ({bus_if.illegal, bus_if.mem_read_enable, bus_if.mem_write_enable, bus_if.reg_read_enable,
         bus_if.reg_write_enable, bus_if.jump, bus_if.immediate} !== {1'b1, 5'b0, 32'd0}) begin
      errors++; $display("FAIL illegal got=%b/%b%b%b%b%b/%h exp=1/00000/00000000", bus_if.illegal,
        bus_if.mem_read_enable, bus_if.mem_write_enable, bus_if.reg_read_enable,
        bus_if.reg_write_enable, bus_if.jump, bus_if.immediate);
    end
  endtask

  // Pulses of 1 and 3 cycles (both shorter than the 4-cycle window) must never reach btn_clean.
  task automatic test_debounce_glitch();
    int widths[2] = '{1, 3};
    foreach (widths[w]) begin
      @(posedge clk); #2 btn_raw = 1'b1;
      repeat (widths[w]) @(posedge clk);
      #2 btn_raw = 1'b0;
      for (int k = 0; k < 8; k++) begin
        @(posedge clk); #1 checks++;
        if (btn_clean !== 1'b0) begin
          errors++; $display("FAIL glitch_w%0d_c%0d got=%b exp=0", widths[w], k, btn_clean);
        end
      end
    end
  endtask

  task automatic test_debounce_hold();
    @(posedge clk); #2 btn_raw = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk); #1 checks++;
      if (btn_clean !== (k >= 6)) begin
        errors++; $display("FAIL hold_edge%0d got=%b exp=%b", k, btn_clean, k >= 6);
      end
    end
  endtask

  task automatic test_debounce_reset();
    // Release counting toward 0, then reset asynchronously partway through.
    @(posedge clk); #2 btn_raw = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 checks++;
    if (btn_clean !== 1'b0) begin errors++; $display("FAIL reset_midcount got=%b exp=0", btn_clean); end
    // Held press interrupted by reset: count must restart from scratch after release.
    #2 btn_raw = 1'b1; reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1 checks++;
    if (btn_clean !== 1'b0) begin errors++; $display("FAIL reset_rising got=%b exp=0", btn_clean); end
    @(posedge clk); #2 reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1 checks++;
      if (btn_clean !== (k >= 6)) begin
        errors++; $display("FAIL restart_edge%0d got=%b exp=%b", k, btn_clean, k >= 6);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
    logic [31:0] ins, pc, a, b;
    dec_t exp_v, obs;
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      ins[6:0] = ops[$urandom_range(0, 9)];
      if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
      pc = $urandom & 32'hFFFF_FFFC;
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = 32'($urandom_range(0, 40));
        default: b = $urandom;
      endcase
      apply(ins, pc, a, b);
      model(ins, pc, a, b, exp_v);
      obs = observe();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random_%0d ins=%h pc=%h a=%h b=%h got=%h exp=%h", n, ins, pc, a, b, obs, exp_v);
      end
    end
  endtask

  initial begin
    apply(32'h0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_add_sub();
    test_addi_sw();
    test_branch_jal();
    test_illegal();
    test_debounce_glitch();
    test_debounce_hold();
    test_debounce_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
